// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per req/ack handshake and keeps it
// stable for the datapath until advance, then commits the branch/jump next PC.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        InvZero,
    input  logic        Zero,
    input  logic [31:0] jr_target,
    output logic [1:0]  dbg_state
);

    // Handshake: a fetch completes on a rising edge where imem_req=1 and imem_ack=1;
    // an instruction retires on a rising edge where instr_valid=1 and advance=1.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg) begin
            next_pc = jr_target & 32'hFFFF_FFFC;
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && (Zero ^ InvZero)) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        case (state_q)
            S_BOOT: begin
                req_d   = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (advance) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, handshake timing, next-PC
// selection (branch/bne/jump/jr), PC wrap and reset during a pending fetch.
module tb_instruction_fetch_unit;
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        advance = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        JumpReg = 1'b0;
    logic        InvZero = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
        .pc_plus4(pc_plus4), .advance(advance), .Branch(Branch), .Jump(Jump),
        .JumpReg(JumpReg), .InvZero(InvZero), .Zero(Zero), .jr_target(jr_target),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctrl();
        advance = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        InvZero = 1'b0; Zero = 1'b0; jr_target = 32'h0;
    endtask

    // From a FETCH cycle: deliver rdata, then retire it with the given flags.
    task automatic fetch_issue(input string tag, input logic [31:0] rdata,
                               input logic jr, input logic j, input logic br,
                               input logic z, input logic inv, input logic [31:0] jrt);
        check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack = 1'b0;
        check({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
        check({tag, "_instr"}, instruction, rdata);
        JumpReg = jr; Jump = j; Branch = br; Zero = z; InvZero = inv; jr_target = jrt;
        advance = 1'b1;
        tick();
        clear_ctrl();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        fetch_issue("goto", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, target);
    endtask

    initial begin
        logic [31:0] words[3];
        words[0] = 32'h2008_0005;
        words[1] = 32'h0109_5020;
        words[2] = 32'hAC0A_0010;

        // reset state
        @(negedge clk);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_state", {30'h0, dbg_state}, {30'h0, ST_BOOT});
        reset = 1'b0;
        tick();
        check("boot_exit_req", {31'h0, imem_req}, 32'h1);
        check("boot_exit_state", {30'h0, dbg_state}, {30'h0, ST_FETCH});

        // ack and advance tied high: two cycles per instruction
        imem_ack = 1'b1;
        advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stream_addr", imem_addr, 32'(i * 4));
            check("stream_fetch_valid", {31'h0, instr_valid}, 32'h0);
            imem_rdata = words[i];
            tick();
            check("stream_valid", {31'h0, instr_valid}, 32'h1);
            check("stream_instr", instruction, words[i]);
            check("stream_req_low", {31'h0, imem_req}, 32'h0);
            check("stream_pc4", pc_plus4, 32'(i * 4 + 4));
            tick();
        end
        imem_ack = 1'b0;
        clear_ctrl();
        check("stream_next_addr", imem_addr, 32'hC);

        // ack delayed by three cycles, advance during FETCH ignored
        goto_pc(32'h40);
        advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'h0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'h40);
            check("wait_valid", {31'h0, instr_valid}, 32'h0);
            tick();
        end
        check("wait_req4", {31'h0, imem_req}, 32'h1);
        check("wait_addr4", imem_addr, 32'h40);
        advance = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        check("wait_valid_rise", {31'h0, instr_valid}, 32'h1);
        check("wait_instr", instruction, 32'h1234_5678);
        check("wait_state", {30'h0, dbg_state}, {30'h0, ST_ISSUE});
        // holding in ISSUE without advance
        tick();
        check("issue_hold_valid", {31'h0, instr_valid}, 32'h1);
        check("issue_hold_addr", imem_addr, 32'h40);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check("wait_next_addr", imem_addr, 32'h44);

        // branches at PC=0x10, imm16 = -4
        goto_pc(32'h10);
        fetch_issue("beq_taken", 32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("beq_taken_addr", imem_addr, 32'h04);
        goto_pc(32'h10);
        fetch_issue("beq_not", 32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("beq_not_addr", imem_addr, 32'h14);
        goto_pc(32'h10);
        fetch_issue("bne_taken", 32'h1400_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        check("bne_taken_addr", imem_addr, 32'h04);
        goto_pc(32'h10);
        fetch_issue("bne_not", 32'h1400_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        check("bne_not_addr", imem_addr, 32'h14);
        goto_pc(32'h10);
        fetch_issue("beq_fwd", 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("beq_fwd_addr", imem_addr, 32'h20);

        // jumps
        goto_pc(32'h3000_0000);
        check("j_start_addr", imem_addr, 32'h3000_0000);
        fetch_issue("j", 32'h0800_0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("j_addr", imem_addr, 32'h3000_0100);
        fetch_issue("jr_prio", 32'h0800_0040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0207);
        check("jr_prio_addr", imem_addr, 32'h0000_0204);

        // PC wrap
        goto_pc(32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc4_fetch", pc_plus4, 32'h0);
        fetch_issue("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_pc4_after", pc_plus4, 32'h4);

        // reset during a pending fetch, stale ack right after release
        goto_pc(32'h80);
        check("rst_mid_addr", imem_addr, 32'h80);
        check("rst_mid_req", {31'h0, imem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_async_addr", imem_addr, 32'h0);
        check("rst_async_req", {31'h0, imem_req}, 32'h0);
        check("rst_async_state", {30'h0, dbg_state}, {30'h0, ST_BOOT});
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        check("boot_req", {31'h0, imem_req}, 32'h0);
        tick();
        imem_ack = 1'b0;
        check("stale_instr", instruction, 32'h0);
        check("stale_valid", {31'h0, instr_valid}, 32'h0);
        check("stale_req", {31'h0, imem_req}, 32'h1);
        check("stale_addr", imem_addr, 32'h0);
        fetch_issue("post_rst", 32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("post_rst_addr", imem_addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'h1, 32'h0);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
